rom_loader: RTL

Writer-side counterpart of the `rom` read port: accepts a byte stream over a valid/ready handshake and writes it sequentially into a 512x8 on-chip memory. The memory is exposed through the same synchronous `address`/`data` read interface as `rom`, so existing ROM sweep benches can compare it against a golden `rom` once loading completes. It also maintains an accept count and an 8-bit checksum so the host can confirm the load.

---
 rtl/rom_loader_pkg.sv | 15 +
 rtl/rom_loader_if.sv | 25 ++
 rtl/rom_loader_mem.sv | 29 ++
 rtl/rom_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and default geometry for the ROM loader and its memory.
// The default geometry matches the golden rom it is compared against.
package rom_loader_pkg;

  localparam int unsigned ROM_DEPTH  = 512;
  localparam int unsigned ROM_ADDR_W = 9;
  localparam int unsigned ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream valid/ready channel that feeds the ROM loader.
// The master drives in_valid and in_data. The slave drives in_ready.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int unsigned DATA_W = ROM_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/rom_loader_mem.sv
// Simple dual-port memory: one write port and one registered read-first read port.
// The memory has no reset, so its contents survive a reset of the surrounding logic.
module rom_loader_mem #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read and write on the same edge return the old word on an address collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rom_loader.sv
// Loads a byte stream sequentially into on-chip memory and keeps an accept count and a checksum.
// The memory is exposed through a rom-compatible synchronous read port.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = ROM_DEPTH,
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  rom_loader_if.slave       s_if,
  input  logic [ADDR_W-1:0] address_i,
  output logic [DATA_W-1:0] data_o,
  output logic              loading_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic [DATA_W-1:0] checksum_o
);

  if (ADDR_W != $clog2(DEPTH)) begin : gen_bad_addr_w
    $error("ADDR_W must equal $clog2(DEPTH)");
  end

  localparam logic [ADDR_W:0] CountLast = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rdata;
  logic              accept;
  logic              clear;

  assign accept = (state_q == LOAD) && s_if.in_valid;
  // A start request is honoured only outside LOAD.
  assign clear  = start_i && (state_q != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (accept && (count_q == CountLast)) state_d = DONE;
      DONE:    if (start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_if.in_ready = (state_q == LOAD);
    loading_o     = (state_q == LOAD);
    done_o        = (state_q == DONE);
    // Mask the unreset read register until one edge has passed after reset.
    data_o        = rd_valid_q ? rdata : '0;
  end

  always_comb begin
    count_d    = count_q;
    checksum_d = checksum_q;
    if (clear) begin
      count_d    = '0;
      checksum_d = '0;
    end else if (accept) begin
      count_d    = count_q + CountOne;
      checksum_d = checksum_q + s_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      checksum_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      checksum_q <= checksum_d;
      rd_valid_q <= 1'b1;
    end
  end

  assign count_o    = count_q;
  assign checksum_o = checksum_q;

  rom_loader_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (count_q[ADDR_W-1:0]),
    .wdata_i (s_if.in_data),
    .raddr_i (address_i),
    .rdata_o (rdata)
  );

endmodule
